memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//   MEM stage of the 5-stage pipeline; sits between the execute stage and writeback.
//   - Waits for load data from the data SRAM, which may arrive late. Stalls upstream while it waits.
//   - Aligns and extends load data (LW/LB/LBU/LH/LHU/LWL/LWR).
//   - Holds the HI/LO pair written by mult/div completion.
//   - Registers the writeback request.
// PARAMETERS
//   RD_TIMEOUT  255  max cycles in WAIT_RD before abort; 0 = no timeout
// PORTS
//   clk               in   1   clock, all state on rising edge
//   resetn            in   1   asynchronous active-low reset
//   exe_valid         in   1   execute stage presents an instruction this cycle
//   exe_reg_en        in   1   instruction writes a GPR
//   exe_mem_read      in   1   instruction is a load
//   exe_reg_waddr     in   6   destination register
//   alu_result_reg    in   32  ALU result / load address
//   exe_load_type     in   3   000 LW,001 LB,010 LBU,011 LH,100 LHU,101 LWL,110 LWR
//   exe_load_rt_data  in   32  old rt value (LWL/LWR merge)
//   exe_double_en     in   1   mult/div result valid
//   exe_MD_result     in   64  {HI,LO} result
//   data_sram_rdata   in   32  word read from data SRAM
//   data_sram_rvalid  in   1   rdata valid this cycle
//   mem_busy          out  1   stall upstream (combinational)
//   mem_reg_en        out  1   WB write enable
//   mem_reg_waddr     out  6   WB destination
//   mem_reg_wdata     out  32  WB data
//   mem_hi, mem_lo    out  32  HI/LO registers
//   mem_timeout       out  1   1-cycle pulse: load aborted by timeout
//   mem_adel          out  1   1-cycle pulse: misaligned load (see CONFIGURATION)
// BEHAVIOUR
//   - Reset: state=IDLE, wait counter=0. All outputs are 0, including mem_hi/mem_lo.
//   - FSM IDLE:
//     - Non-load (exe_valid & !exe_mem_read): next cycle mem_reg_en/waddr = exe values, wdata = alu_result_reg.
//     - Load with data_sram_rvalid=1: formatted result is registered next cycle (1-cycle latency).
//     - Load with rvalid=0: capture waddr/addr[1:0]/type/rt/reg_en into hold regs, go to WAIT_RD.
//       In that cycle mem_busy=1, and mem_reg_en=0 the next cycle.
//     - exe_valid=0: mem_reg_en=0 next cycle (bubble).
//   - FSM WAIT_RD:
//     - mem_busy=1 every cycle; exe_* inputs other than exe_double_en are ignored.
//     - On rvalid=1: format from hold regs, register it, return to IDLE (mem_busy=0 that cycle).
//     - Otherwise increment counter and emit mem_reg_en=0.
//     - If RD_TIMEOUT!=0 and counter reaches RD_TIMEOUT: pulse mem_timeout, write nothing, return to IDLE.
//   - rvalid while IDLE and no load: ignored.
//   - HI/LO: exe_double_en=1 -> {mem_hi,mem_lo} <= exe_MD_result next cycle, in any state.
//   - Load formatting: r=rdata, t=rt, a=addr[1:0].
//     - LB/LBU: byte a, sign-/zero-extended. LH/LHU: half a[1], sign-/zero-extended. LW: r.
//     - LWL: a=0 {r[7:0],t[23:0]}; a=1 {r[15:0],t[15:0]}; a=2 {r[23:0],t[7:0]}; a=3 r.
//     - LWR: a=0 r; a=1 {t[31:24],r[31:8]}; a=2 {t[31:16],r[31:16]}; a=3 {t[31:8],r[31:24]}.
//     - Undefined type codes (111) -> r.
//   - Reset mid-WAIT_RD: aborts immediately to IDLE; the pending load is lost, no write.
// CONFIGURATION
//   - MEM_ADEL_CHECK_EN defined:
//     - LW with a!=0, or LH/LHU with a[0]=1, is a misaligned load.
//     - It pulses mem_adel the next cycle with mem_reg_en=0 and no WAIT_RD entry.
//   - Undefined: mem_adel is tied 0; misaligned loads are formatted per the rules above.
// TESTING
//   1. LB addr 0x...3, rdata 0x80FF_FF12, rvalid same cycle -> next cycle wdata 0xFFFF_FF80, reg_en=1.
//   2. LWR addr 0x...2, rt 0xAABB_CCDD, rdata 0x1122_3344, rvalid after 3 cycles
//      -> mem_busy=1 for exactly 3 cycles, then wdata 0xAABB_1122.
//   3. exe_double_en with MD 0x0000_0001_FFFF_FFFE during WAIT_RD -> hi=0x1, lo=0xFFFF_FFFE next cycle; load still completes.
//   4. RD_TIMEOUT=4, load with rvalid never high -> mem_timeout pulse after 4 wait cycles, IDLE, no write.
//   5. resetn low while in WAIT_RD -> all outputs 0 asynchronously; the next ALU op passes through normally.
//   6. MEM_ADEL_CHECK_EN defined, LH addr 0x...1 -> mem_adel=1, mem_reg_en=0, mem_busy=0.

Source files
------------

// File: rtl/memory_stage.sv
// memory_stage: MEM stage; load wait/format, HI/LO hold, WB register (optional MEM_ADEL_CHECK_EN misalignment check)
module memory_stage #(
  parameter int RD_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        exe_valid,
  input  logic        exe_reg_en,
  input  logic        exe_mem_read,
  input  logic [5:0]  exe_reg_waddr,
  input  logic [31:0] alu_result_reg,
  input  logic [2:0]  exe_load_type,
  input  logic [31:0] exe_load_rt_data,
  input  logic        exe_double_en,
  input  logic [63:0] exe_MD_result,
  input  logic [31:0] data_sram_rdata,
  input  logic        data_sram_rvalid,
  output logic        mem_busy,
  output logic        mem_reg_en,
  output logic [5:0]  mem_reg_waddr,
  output logic [31:0] mem_reg_wdata,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_timeout,
  output logic        mem_adel
);
  localparam int CW = RD_TIMEOUT > 1 ? $clog2(RD_TIMEOUT) : 1;
  typedef enum logic {IDLE, WAIT_RD} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [5:0] h_waddr, waddr_nx;
  logic [1:0] h_a;
  logic [2:0] h_type;
  logic [31:0] h_rt, wdata_nx, fmt;
  logic h_reg_en, wen_nx, tmo_nx, adel_nx, cap, misal, is_load;

  function automatic logic [31:0] load_fmt(input logic [2:0] ty, input logic [1:0] a,
                                           input logic [31:0] r, input logic [31:0] t);
    logic [7:0] b;
    logic [15:0] h;
    b = r[{a, 3'b000} +: 8];
    h = a[1] ? r[31:16] : r[15:0];
    case (ty)
      3'd1: load_fmt = {{24{b[7]}}, b};
      3'd2: load_fmt = {24'd0, b};
      3'd3: load_fmt = {{16{h[15]}}, h};
      3'd4: load_fmt = {16'd0, h};
      3'd5: load_fmt = a == 2'd0 ? {r[7:0], t[23:0]} : a == 2'd1 ? {r[15:0], t[15:0]} :
                       a == 2'd2 ? {r[23:0], t[7:0]} : r;
      3'd6: load_fmt = a == 2'd0 ? r : a == 2'd1 ? {t[31:24], r[31:8]} :
                       a == 2'd2 ? {t[31:16], r[31:16]} : {t[31:8], r[31:24]};
      default: load_fmt = r;
    endcase
  endfunction

  assign is_load = exe_valid & exe_mem_read;
`ifdef MEM_ADEL_CHECK_EN
  assign misal = is_load & ((exe_load_type == 3'd0 & alu_result_reg[1:0] != 2'd0) |
                 ((exe_load_type == 3'd3 | exe_load_type == 3'd4) & alu_result_reg[0]));
`else
  assign misal = 1'b0;
`endif
  assign fmt = state == WAIT_RD ? load_fmt(h_type, h_a, data_sram_rdata, h_rt)
                                : load_fmt(exe_load_type, alu_result_reg[1:0], data_sram_rdata, exe_load_rt_data);

  // next state, stall and writeback selection
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    wen_nx = 1'b0;
    waddr_nx = mem_reg_waddr;
    wdata_nx = mem_reg_wdata;
    tmo_nx = 1'b0;
    adel_nx = 1'b0;
    mem_busy = 1'b0;
    cap = 1'b0;
    if (state == IDLE) begin
      if (exe_valid & ~exe_mem_read) begin
        wen_nx = exe_reg_en;
        waddr_nx = exe_reg_waddr;
        wdata_nx = alu_result_reg;
      end else if (misal) begin
        adel_nx = 1'b1;
      end else if (is_load & data_sram_rvalid) begin
        wen_nx = exe_reg_en;
        waddr_nx = exe_reg_waddr;
        wdata_nx = fmt;
      end else if (is_load) begin
        mem_busy = 1'b1;
        cap = 1'b1;
        state_nx = WAIT_RD;
        cnt_nx = '0;
      end
    end else if (data_sram_rvalid) begin
      wen_nx = h_reg_en;
      waddr_nx = h_waddr;
      wdata_nx = fmt;
      state_nx = IDLE;
      cnt_nx = '0;
    end else begin
      mem_busy = 1'b1;
      if (RD_TIMEOUT != 0 && cnt == CW'(RD_TIMEOUT - 1)) begin
        tmo_nx = 1'b1;
        state_nx = IDLE;
        cnt_nx = '0;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
    end
  end

  // state, hold registers and writeback outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      h_waddr <= '0;
      h_a <= '0;
      h_type <= '0;
      h_rt <= '0;
      h_reg_en <= 1'b0;
      mem_reg_en <= 1'b0;
      mem_reg_waddr <= '0;
      mem_reg_wdata <= '0;
      mem_timeout <= 1'b0;
      mem_adel <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (cap) begin
        h_waddr <= exe_reg_waddr;
        h_a <= alu_result_reg[1:0];
        h_type <= exe_load_type;
        h_rt <= exe_load_rt_data;
        h_reg_en <= exe_reg_en;
      end
      mem_reg_en <= wen_nx;
      mem_reg_waddr <= waddr_nx;
      mem_reg_wdata <= wdata_nx;
      mem_timeout <= tmo_nx;
      mem_adel <= adel_nx;
    end
  end

  // HI/LO follow mult/div completion regardless of load state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) {mem_hi, mem_lo} <= '0;
    else if (exe_double_en) {mem_hi, mem_lo} <= exe_MD_result;
  end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: vector table, corner sequences and random run against a reference model
module tb_memory_stage;
  localparam int TMO = 4;
  logic clk = 1'b0, resetn = 1'b0;
  logic exe_valid = 0, exe_reg_en = 0, exe_mem_read = 0, exe_double_en = 0, rvalid = 0;
  logic [5:0] exe_reg_waddr = 0;
  logic [31:0] alu = 0, rt = 0, rdata = 0;
  logic [2:0] ty = 0;
  logic [63:0] md = 0;
  logic mem_busy, mem_reg_en, mem_timeout, mem_adel;
  logic [5:0] mem_reg_waddr;
  logic [31:0] mem_reg_wdata, mem_hi, mem_lo;
  int n_chk = 0, n_fail = 0, busy_cnt = 0;
  logic e_busy, e_en, e_tmo, e_adel;
  logic [5:0] e_waddr;
  logic [31:0] e_wdata, e_hi, e_lo;
  bit m_pend;
  int m_wait;
  logic [5:0] h_waddr;
  logic [1:0] h_a;
  logic [2:0] h_ty;
  logic [31:0] h_rt;
  logic h_en;

  typedef struct {logic rd; logic [2:0] ty; logic [1:0] a; logic [31:0] r; logic [31:0] t; logic [31:0] exp;} vec_t;
  vec_t tbl[12];

  memory_stage #(.RD_TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn), .exe_valid(exe_valid), .exe_reg_en(exe_reg_en),
    .exe_mem_read(exe_mem_read), .exe_reg_waddr(exe_reg_waddr), .alu_result_reg(alu),
    .exe_load_type(ty), .exe_load_rt_data(rt), .exe_double_en(exe_double_en),
    .exe_MD_result(md), .data_sram_rdata(rdata), .data_sram_rvalid(rvalid),
    .mem_busy(mem_busy), .mem_reg_en(mem_reg_en), .mem_reg_waddr(mem_reg_waddr),
    .mem_reg_wdata(mem_reg_wdata), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_timeout(mem_timeout), .mem_adel(mem_adel));

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_fmt(logic [2:0] t_, logic [1:0] a, logic [31:0] r, logic [31:0] t);
    int sh;
    logic [7:0] b;
    logic [15:0] h;
    b = 8'(r >> (8 * a));
    h = 16'(r >> (16 * a[1]));
    case (t_)
      3'd1: return 32'($signed(b));
      3'd2: return 32'(b);
      3'd3: return 32'($signed(h));
      3'd4: return 32'(h);
      3'd5: begin
        sh = 8 * (3 - a);
        return 32'((64'(r) << sh) | (64'(t) & ((64'd1 << sh) - 64'd1)));
      end
      3'd6: begin
        sh = 8 * a;
        return (r >> sh) | (t & ~(32'hFFFF_FFFF >> sh));
      end
      default: return r;
    endcase
  endfunction

  function automatic bit ref_misal(logic [2:0] t_, logic [1:0] a);
`ifdef MEM_ADEL_CHECK_EN
    return (t_ == 3'd0 && a != 2'd0) || ((t_ == 3'd3 || t_ == 3'd4) && a[0]);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_wait = 0;
    e_en = 0; e_waddr = 0; e_wdata = 0; e_hi = 0; e_lo = 0; e_tmo = 0; e_adel = 0;
  endtask

  task automatic model();
    e_tmo = 0; e_adel = 0; e_en = 0; e_busy = 0;
    if (exe_double_en) {e_hi, e_lo} = md;
    if (m_pend) begin
      if (rvalid) begin
        e_en = h_en; e_waddr = h_waddr; e_wdata = ref_fmt(h_ty, h_a, rdata, h_rt); m_pend = 0;
      end else begin
        e_busy = 1; m_wait++;
        if (TMO != 0 && m_wait == TMO) begin e_tmo = 1; m_pend = 0; end
      end
    end else if (exe_valid && !exe_mem_read) begin
      e_en = exe_reg_en; e_waddr = exe_reg_waddr; e_wdata = alu;
    end else if (exe_valid) begin
      if (ref_misal(ty, alu[1:0])) e_adel = 1;
      else if (rvalid) begin
        e_en = exe_reg_en; e_waddr = exe_reg_waddr; e_wdata = ref_fmt(ty, alu[1:0], rdata, rt);
      end else begin
        e_busy = 1; m_pend = 1; m_wait = 0;
        h_en = exe_reg_en; h_waddr = exe_reg_waddr; h_ty = ty; h_a = alu[1:0]; h_rt = rt;
      end
    end
  endtask

  task automatic check_outs();
    chk("reg_en", mem_reg_en, e_en);
    if (e_en) begin
      chk("waddr", mem_reg_waddr, e_waddr);
      chk("wdata", mem_reg_wdata, e_wdata);
    end
    chk("hi", mem_hi, e_hi);
    chk("lo", mem_lo, e_lo);
    chk("timeout", mem_timeout, e_tmo);
    chk("adel", mem_adel, e_adel);
  endtask

  // called at negedge with inputs already driven; returns at the next negedge
  task automatic step();
    #1;
    model();
    if (mem_busy === 1'b1) busy_cnt++;
    chk("busy", mem_busy, e_busy);
    @(posedge clk);
    @(negedge clk);
    check_outs();
  endtask

  task automatic drive(logic v, logic rd, logic [2:0] t_, logic [31:0] ad, logic [31:0] t, logic [31:0] r, logic rv);
    exe_valid = v; exe_mem_read = rd; ty = t_; alu = ad; rt = t; rdata = r; rvalid = rv;
    exe_reg_en = 1; exe_reg_waddr = 6'(ad[7:2] ^ 6'h15); exe_double_en = 0;
  endtask

  initial begin
    tbl[0]  = '{1, 3'd1, 2'd3, 32'h80FF_FF12, 32'h0, 32'hFFFF_FF80};
    tbl[1]  = '{1, 3'd0, 2'd0, 32'h1122_3344, 32'h0, 32'h1122_3344};
    tbl[2]  = '{1, 3'd2, 2'd0, 32'h80FF_FF12, 32'h0, 32'h0000_0012};
    tbl[3]  = '{1, 3'd2, 2'd3, 32'h80FF_FF12, 32'h0, 32'h0000_0080};
    tbl[4]  = '{1, 3'd3, 2'd2, 32'h80FF_1234, 32'h0, 32'hFFFF_80FF};
    tbl[5]  = '{1, 3'd4, 2'd0, 32'h80FF_F234, 32'h0, 32'h0000_F234};
    tbl[6]  = '{1, 3'd3, 2'd0, 32'h0000_F234, 32'h0, 32'hFFFF_F234};
    tbl[7]  = '{1, 3'd5, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 32'h3344_CCDD};
    tbl[8]  = '{1, 3'd5, 2'd0, 32'h1122_3344, 32'hAABB_CCDD, 32'h44BB_CCDD};
    tbl[9]  = '{1, 3'd6, 2'd3, 32'h1122_3344, 32'hAABB_CCDD, 32'hAABB_CC11};
    tbl[10] = '{1, 3'd6, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 32'hAA11_2233};
    tbl[11] = '{0, 3'd0, 2'd3, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF};
    model_reset();
    repeat (2) @(negedge clk);
    check_outs();
    chk("rst_busy", mem_busy, 1'b0);
    resetn = 1;
    for (int i = 0; i < 12; i++) begin
      drive(1, tbl[i].rd, tbl[i].ty, tbl[i].rd ? {30'h0400_0000, tbl[i].a} : tbl[i].r,
            tbl[i].t, tbl[i].r, 1);
      step();
      chk($sformatf("tbl%0d_en", i), mem_reg_en, 1'b1);
      chk($sformatf("tbl%0d_wdata", i), mem_reg_wdata, tbl[i].exp);
    end
    // late LWR: three busy cycles then merged data
    busy_cnt = 0;
    drive(1, 1, 3'd6, 32'h0400_0002, 32'hAABB_CCDD, 32'h0, 0);
    step();
    chk("lwr_bubble", mem_reg_en, 1'b0);
    drive(1, 1, 3'd1, 32'h0400_0011, 32'h5555_5555, 32'h0, 0);
    step();
    step();
    drive(0, 0, 3'd0, 32'h0, 32'h0, 32'h1122_3344, 1);
    step();
    chk("lwr_busy_cycles", busy_cnt, 3);
    chk("lwr_wdata", mem_reg_wdata, 32'hAABB_1122);
    chk("lwr_en", mem_reg_en, 1'b1);
    // HI/LO written while a load is waiting
    drive(1, 1, 3'd0, 32'h0400_0020, 32'h0, 32'h0, 0);
    step();
    drive(0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 0);
    exe_double_en = 1; md = 64'h0000_0001_FFFF_FFFE;
    step();
    chk("md_hi", mem_hi, 32'h1);
    chk("md_lo", mem_lo, 32'hFFFF_FFFE);
    drive(0, 0, 3'd0, 32'h0, 32'h0, 32'hCAFE_F00D, 1);
    step();
    chk("md_load_done", mem_reg_wdata, 32'hCAFE_F00D);
    // timeout after TMO wait cycles
    drive(1, 1, 3'd0, 32'h0400_0030, 32'h0, 32'h0, 0);
    step();
    drive(0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 0);
    for (int i = 1; i <= TMO; i++) begin
      step();
      chk($sformatf("tmo_pulse%0d", i), mem_timeout, i == TMO);
      chk($sformatf("tmo_nowrite%0d", i), mem_reg_en, 1'b0);
    end
    step();
    chk("tmo_clear", mem_timeout, 1'b0);
    // asynchronous reset in WAIT_RD
    drive(1, 1, 3'd0, 32'h0400_0040, 32'h0, 32'h0, 0);
    step();
    drive(0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 0);
    #2 resetn = 0;
    #1;
    model_reset();
    check_outs();
    chk("rst_wdata", mem_reg_wdata, 32'h0);
    chk("rst_waddr", mem_reg_waddr, 6'h0);
    @(negedge clk);
    resetn = 1;
    drive(1, 0, 3'd0, 32'h1234_5678, 32'h0, 32'h0, 1);
    step();
    chk("post_rst_alu", mem_reg_wdata, 32'h1234_5678);
`ifdef MEM_ADEL_CHECK_EN
    drive(1, 1, 3'd3, 32'h0400_0001, 32'h0, 32'h0, 0);
    #1;
    chk("adel_busy", mem_busy, 1'b0);
    step();
    chk("adel_pulse", mem_adel, 1'b1);
    chk("adel_en", mem_reg_en, 1'b0);
`endif
    // random traffic
    for (int i = 0; i < 600; i++) begin
      exe_valid = 1'($urandom_range(0, 3) != 0);
      exe_mem_read = 1'($urandom_range(0, 1));
      exe_reg_en = 1'($urandom_range(0, 3) != 0);
      exe_reg_waddr = 6'($urandom);
      alu = $urandom;
      ty = 3'($urandom);
      rt = $urandom;
      rdata = $urandom;
      rvalid = 1'($urandom_range(0, 2) == 0);
      exe_double_en = 1'($urandom_range(0, 4) == 0);
      md = {$urandom, $urandom};
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
